vc_pop_arbiter: RTL and testbench

Read-side controller for the two virtual-channel FIFOs (VC0, VC1) of the transmit path. Inspects each FIFO's head-of-line preview word, arbitrates between the non-empty channels, pops one word and forwards it to one of two destination FIFOs (D0, D1), selected by a routing bit in the word. Destination almost-full flags provide backpressure. The block sits between the VC FIFOs and the per-destination output FIFOs.

---
 rtl/vc_pop_arbiter_pkg.sv | 20 ++
 rtl/vc_rr_arbiter.sv | 45 ++++
 rtl/vc_pop_arbiter.sv | 126 ++++++++++++
 tb/tb_vc_pop_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pop_arbiter_pkg.sv
// Shared types and defaults for the VC pop arbiter.
// Holds the FSM state encoding and the default word/routing geometry.
package vc_pop_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 6;
  localparam int unsigned DEF_DEST_BIT   = 4;
  localparam int unsigned DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // A channel is blocked when the destination its head word routes to is almost full.
  function automatic logic route_blocked(input logic dest, input logic af0, input logic af1);
    return dest ? af1 : af0;
  endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Two-requester grant logic for the VC pop arbiter.
// VC_POP_RR_EN defined: round-robin with last-grant pointer; undefined: VC0 fixed priority.
module vc_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;

`ifdef VC_POP_RR_EN
  logic ptr;

  // ptr names the channel preferred on a tie; it moves away from whoever was granted.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) grant = ptr;
    else              grant = req[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (!init) begin
      ptr <= 1'b0;
    end else if (take && valid) begin
      ptr <= ~grant;
    end
  end
`else
  logic unused_ctl;

  assign unused_ctl = ^{clk, reset, init, take};

  always_comb begin
    grant = 1'b0;
    if (!req[0]) grant = req[1];
  end
`endif

endmodule

// File: rtl/vc_pop_arbiter.sv
// Read-side controller: arbitrates VC0/VC1, pops one word, pushes it to D0/D1.
// Arbitration policy selected by VC_POP_RR_EN (see vc_rr_arbiter).
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEST_BIT   = DEF_DEST_BIT,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_preview,
  input  logic [DATA_WIDTH-1:0] vc1_preview,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  vc0_rd_en,
  output logic                  vc1_rd_en,
  output logic                  d0_wr_en,
  output logic                  d1_wr_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  active_vc,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  cnt_d0,
  output logic [CNT_WIDTH-1:0]  cnt_d1
);

  state_t state, state_nxt;
  logic   sel_vc, sel_dest;
  logic   elig0, elig1;
  logic   grant_vc, grant_valid;
  logic   take;
  logic   unused_preview;

  assign unused_preview = ^{vc0_preview, vc1_preview};

  // Preview is only trustworthy in IDLE, so eligibility is consumed there only.
  assign elig0 = ~vc0_empty &
                 ~route_blocked(vc0_preview[DEST_BIT], d0_almost_full, d1_almost_full);
  assign elig1 = ~vc1_empty &
                 ~route_blocked(vc1_preview[DEST_BIT], d0_almost_full, d1_almost_full);
  assign take  = (state == ST_IDLE);

  vc_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .req   ({elig1, elig0}),
    .take  (take),
    .grant (grant_vc),
    .valid (grant_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_valid) state_nxt = ST_POP;
      ST_POP:  state_nxt = ST_XFER;
      ST_XFER: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (!init) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      sel_vc   <= 1'b0;
      sel_dest <= 1'b0;
    end else if (!init) begin
      state    <= ST_IDLE;
      sel_vc   <= 1'b0;
      sel_dest <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take && grant_valid) begin
        sel_vc   <= grant_vc;
        sel_dest <= grant_vc ? vc1_preview[DEST_BIT] : vc0_preview[DEST_BIT];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_d0 <= '0;
      cnt_d1 <= '0;
    end else if (!init) begin
      cnt_d0 <= '0;
      cnt_d1 <= '0;
    end else if (state == ST_XFER) begin
      if (sel_dest) cnt_d1 <= cnt_d1 + CNT_WIDTH'(1);
      else          cnt_d0 <= cnt_d0 + CNT_WIDTH'(1);
    end
  end

  // Strobes decode from registered state only, so an async reset clears them at once.
  always_comb begin
    vc0_rd_en = 1'b0;
    vc1_rd_en = 1'b0;
    d0_wr_en  = 1'b0;
    d1_wr_en  = 1'b0;
    data_out  = '0;
    active_vc = 1'b0;
    idle      = 1'b0;
    case (state)
      ST_IDLE: idle = 1'b1;
      ST_POP: begin
        vc0_rd_en = ~sel_vc;
        vc1_rd_en = sel_vc;
        active_vc = sel_vc;
      end
      ST_XFER: begin
        d0_wr_en  = ~sel_dest;
        d1_wr_en  = sel_dest;
        data_out  = sel_vc ? vc1_data : vc0_data;
        active_vc = sel_vc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Self-checking bench for vc_pop_arbiter with behavioural VC FIFOs and a queue-based reference model.
module tb_vc_pop_arbiter;

  localparam int DW = 6;
  localparam int DB = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset, init;
  logic vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic [DW-1:0] vc0_preview = '0, vc1_preview = '0;
  logic [DW-1:0] vc0_data = '0, vc1_data = '0;
  logic d0_af, d1_af;
  logic vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en;
  logic [DW-1:0] data_out;
  logic active_vc, idle;
  logic [CW-1:0] cnt_d0, cnt_d1;

  vc_pop_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_preview(vc0_preview), .vc1_preview(vc1_preview),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_almost_full(d0_af), .d1_almost_full(d1_af),
    .vc0_rd_en(vc0_rd_en), .vc1_rd_en(vc1_rd_en),
    .d0_wr_en(d0_wr_en), .d1_wr_en(d1_wr_en),
    .data_out(data_out), .active_vc(active_vc), .idle(idle),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q0[$], q1[$], mq0[$], mq1[$];
  bit            pop_vc[$];
  int            pop_cyc[$];
  logic [DW:0]   push_log[$];
  bit            exp_pop[$];
  logic [DW:0]   exp_push[$];
  int  errors = 0, checks = 0, viol = 0, cyc = 0;
  bit  model_ptr = 1'b0;
  int  exp_cnt0 = 0, exp_cnt1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model and event recorder: pops on rd_en, logs strobes, refreshes flags.
  always @(negedge clk) begin
    if (reset) begin
      if (int'(vc0_rd_en) + int'(vc1_rd_en) + int'(d0_wr_en) + int'(d1_wr_en) > 1) viol++;
      if (vc0_rd_en) begin
        pop_vc.push_back(1'b0); pop_cyc.push_back(cyc);
        if (q0.size() > 0) vc0_data = q0.pop_front();
      end
      if (vc1_rd_en) begin
        pop_vc.push_back(1'b1); pop_cyc.push_back(cyc);
        if (q1.size() > 0) vc1_data = q1.pop_front();
      end
      if (d0_wr_en) push_log.push_back({1'b0, data_out});
      if (d1_wr_en) push_log.push_back({1'b1, data_out});
    end
    vc0_empty   = (q0.size() == 0);
    vc1_empty   = (q1.size() == 0);
    vc0_preview = (q0.size() > 0) ? q0[0] : '0;
    vc1_preview = (q1.size() > 0) ? q1[0] : '0;
  end

  task automatic load(input bit vc, input logic [DW-1:0] w);
    if (vc) begin q1.push_back(w); mq1.push_back(w); end
    else    begin q0.push_back(w); mq0.push_back(w); end
  endtask

  task automatic clear_logs();
    pop_vc.delete(); pop_cyc.delete(); push_log.delete();
    exp_pop.delete(); exp_push.delete();
  endtask

  task automatic model_init();
    model_ptr = 1'b0; exp_cnt0 = 0; exp_cnt1 = 0;
  endtask

  // Reference: serve heads whose destination is free, one per pass, by policy.
  task automatic model_drain(input bit af0, input bit af1);
    bit e0, e1, g;
    logic [DW-1:0] w;
    forever begin
      e0 = (mq0.size() > 0) && !(mq0[0][DB] ? af1 : af0);
      e1 = (mq1.size() > 0) && !(mq1[0][DB] ? af1 : af0);
      if (!e0 && !e1) break;
`ifdef VC_POP_RR_EN
      g = (e0 && e1) ? model_ptr : e1;
      model_ptr = !g;
`else
      g = !e0;
`endif
      w = g ? mq1.pop_front() : mq0.pop_front();
      exp_pop.push_back(g);
      exp_push.push_back({w[DB], w});
      if (w[DB]) exp_cnt1 = (exp_cnt1 + 1) % (1 << CW);
      else       exp_cnt0 = (exp_cnt0 + 1) % (1 << CW);
    end
  endtask

  task automatic drain(input int budget, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (pop_vc.size() >= exp_pop.size() && push_log.size() >= exp_push.size() && idle) begin
        timeout = 1'b0;
        break;
      end
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; init = 1'b1; d0_af = 1'b0; d1_af = 1'b0;
    q0.delete(); q1.delete(); mq0.delete(); mq1.delete();
    clear_logs(); model_init();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic init_pulse();
    init = 1'b0;
    @(posedge clk); #1;
    init = 1'b1;
    model_init();
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en} !== 4'b0000) begin errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en}); end
    checks++; if (data_out !== '0 || active_vc !== 1'b0) begin errors++;
      $display("FAIL reset_data: data_out=%h active_vc=%b expected 0/0", data_out, active_vc); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (cnt_d0 !== '0 || cnt_d1 !== '0) begin errors++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_d0, cnt_d1); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (idle !== 1'b1 || {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en} !== 4'b0000) begin errors++;
      $display("FAIL reset_quiet: idle=%b strobes=%b expected 1/0000", idle, {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en}); end
  endtask

  task automatic test_single();
    clear_logs();
    load(1'b0, 6'b010011);
    model_drain(1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en} !== 4'b1000 || idle !== 1'b0) begin errors++;
      $display("FAIL single_pop: strobes=%b idle=%b expected 1000/0", {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en}, idle); end
    @(posedge clk); #1;
    checks++; if ({vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en} !== 4'b0001 || idle !== 1'b0) begin errors++;
      $display("FAIL single_push: strobes=%b idle=%b expected 0001/0", {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en}, idle); end
    checks++; if (data_out !== 6'b010011) begin errors++;
      $display("FAIL single_data: got %b expected 010011", data_out); end
    @(posedge clk); #1;
    checks++; if (idle !== 1'b1 || data_out !== '0) begin errors++;
      $display("FAIL single_idle: idle=%b data_out=%h expected 1/0", idle, data_out); end
    checks++; if (cnt_d1 !== CW'(exp_cnt1) || cnt_d1 !== CW'(1)) begin errors++;
      $display("FAIL single_cnt: got %0d expected 1", cnt_d1); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w;
    clear_logs();
    w = DW'($urandom); w[DB] = 1'b0;
    d0_af = 1'b1;
    load(1'b1, w);
    repeat (10) begin
      @(posedge clk); #1;
      checks++; if ({vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en} !== 4'b0000 || idle !== 1'b1) begin errors++;
        $display("FAIL bp_hold: strobes=%b idle=%b expected 0000/1", {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en}, idle); end
    end
    d0_af = 1'b0;
    model_drain(1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en} !== 4'b0100 || active_vc !== 1'b1) begin errors++;
      $display("FAIL bp_pop: strobes=%b active_vc=%b expected 0100/1", {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en}, active_vc); end
    @(posedge clk); #1;
    checks++; if ({vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en} !== 4'b0010 || data_out !== w) begin errors++;
      $display("FAIL bp_push: strobes=%b data=%h expected 0010/%h", {vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en}, data_out, w); end
    @(posedge clk); #1;
    checks++; if (cnt_d0 !== CW'(exp_cnt0)) begin errors++;
      $display("FAIL bp_cnt: got %0d expected %0d", cnt_d0, exp_cnt0); end
  endtask

  task automatic test_contention();
    bit to;
    init_pulse();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      load(1'b0, DW'($urandom));
      load(1'b1, DW'($urandom));
    end
    model_drain(1'b0, 1'b0);
    drain(60, to);
    checks++; if (to) begin errors++; $display("FAIL cont_timeout: drain not done expected done"); end
    checks++; if (pop_vc.size() != 8) begin errors++;
      $display("FAIL cont_count: got %0d pops expected 8", pop_vc.size()); end
    for (int i = 0; i < 8 && i < pop_vc.size(); i++) begin
      checks++;
`ifdef VC_POP_RR_EN
      if (pop_vc[i] !== bit'(i % 2)) begin errors++;
        $display("FAIL cont_order[%0d]: got VC%0d expected VC%0d", i, pop_vc[i], i % 2); end
`else
      if (pop_vc[i] !== bit'(i >= 4)) begin errors++;
        $display("FAIL cont_order[%0d]: got VC%0d expected VC%0d", i, pop_vc[i], i >= 4); end
`endif
      if (i > 0) begin
        checks++; if (pop_cyc[i] - pop_cyc[i-1] != 3) begin errors++;
          $display("FAIL cont_rate[%0d]: got spacing %0d expected 3", i, pop_cyc[i] - pop_cyc[i-1]); end
      end
    end
    for (int i = 0; i < exp_push.size(); i++) begin
      checks++; if (i >= push_log.size() || push_log[i] !== exp_push[i]) begin errors++;
        $display("FAIL cont_push[%0d]: got %h expected %h", i, (i < push_log.size()) ? push_log[i] : 'x, exp_push[i]); end
    end
    checks++; if (cnt_d0 !== CW'(exp_cnt0) || cnt_d1 !== CW'(exp_cnt1)) begin errors++;
      $display("FAIL cont_cnt: got %0d/%0d expected %0d/%0d", cnt_d0, cnt_d1, exp_cnt0, exp_cnt1); end
  endtask

  task automatic test_mixed();
    bit to;
    logic [DW-1:0] w;
    clear_logs();
    d0_af = 1'b1;
    for (int i = 0; i < 2; i++) begin w = DW'($urandom); w[DB] = 1'b0; load(1'b0, w); end
    for (int i = 0; i < 3; i++) begin w = DW'($urandom); w[DB] = 1'b1; load(1'b1, w); end
    model_drain(1'b1, 1'b0);
    drain(40, to);
    checks++; if (to) begin errors++; $display("FAIL mixed_timeout: drain not done expected done"); end
    checks++; if (pop_vc.size() != 3) begin errors++;
      $display("FAIL mixed_count: got %0d pops expected 3", pop_vc.size()); end
    for (int i = 0; i < pop_vc.size(); i++) begin
      checks++; if (pop_vc[i] !== 1'b1) begin errors++;
        $display("FAIL mixed_vc[%0d]: got VC%0d expected VC1", i, pop_vc[i]); end
    end
    for (int i = 0; i < exp_push.size(); i++) begin
      checks++; if (i >= push_log.size() || push_log[i] !== exp_push[i]) begin errors++;
        $display("FAIL mixed_push[%0d]: got %h expected %h", i, (i < push_log.size()) ? push_log[i] : 'x, exp_push[i]); end
    end
    checks++; if (vc0_empty !== 1'b0 || idle !== 1'b1) begin errors++;
      $display("FAIL mixed_wait: vc0_empty=%b idle=%b expected 0/1", vc0_empty, idle); end
    clear_logs();
    d0_af = 1'b0;
    model_drain(1'b0, 1'b0);
    drain(40, to);
    checks++; if (to || pop_vc.size() != 2) begin errors++;
      $display("FAIL mixed_release: got %0d pops timeout=%b expected 2/0", pop_vc.size(), to); end
    checks++; if (cnt_d0 !== CW'(exp_cnt0) || cnt_d1 !== CW'(exp_cnt1)) begin errors++;
      $display("FAIL mixed_cnt: got %0d/%0d expected %0d/%0d", cnt_d0, cnt_d1, exp_cnt0, exp_cnt1); end
  endtask

  task automatic test_init_mid();
    bit to;
    logic [DW-1:0] w;
    init_pulse();
    clear_logs();
    w = DW'($urandom);
    load(1'b0, w);
    mq0.delete();
    @(posedge clk); #1;
    checks++; if (vc0_rd_en !== 1'b1) begin errors++; $display("FAIL init_pop: got %b expected 1", vc0_rd_en); end
    init = 1'b0;
    @(posedge clk); #1;
    checks++; if (idle !== 1'b1 || d0_wr_en !== 1'b0 || d1_wr_en !== 1'b0 || data_out !== '0) begin errors++;
      $display("FAIL init_abort: idle=%b wr=%b%b data=%h expected 1/00/0", idle, d0_wr_en, d1_wr_en, data_out); end
    checks++; if (cnt_d0 !== '0 || cnt_d1 !== '0) begin errors++;
      $display("FAIL init_cnt: got %0d/%0d expected 0/0", cnt_d0, cnt_d1); end
    init = 1'b1;
    model_init();
    clear_logs();
    w = DW'($urandom);
    load(1'b1, w);
    model_drain(1'b0, 1'b0);
    drain(20, to);
    checks++; if (to || push_log.size() != 1 || (push_log.size() == 1 && push_log[0] !== exp_push[0])) begin errors++;
      $display("FAIL init_resume: pushes=%0d timeout=%b expected 1 push of %h", push_log.size(), to, exp_push[0]); end
    checks++; if (cnt_d0 !== CW'(exp_cnt0) || cnt_d1 !== CW'(exp_cnt1)) begin errors++;
      $display("FAIL init_resume_cnt: got %0d/%0d expected %0d/%0d", cnt_d0, cnt_d1, exp_cnt0, exp_cnt1); end
  endtask

  task automatic test_async_reset();
    load(1'b1, DW'($urandom));
    @(posedge clk); #1;
    checks++; if (vc1_rd_en !== 1'b1 || active_vc !== 1'b1) begin errors++;
      $display("FAIL areset_pre: rd=%b active=%b expected 1/1", vc1_rd_en, active_vc); end
    reset = 1'b0;
    #1;
    checks++; if (vc1_rd_en !== 1'b0 || active_vc !== 1'b0 || idle !== 1'b1) begin errors++;
      $display("FAIL areset_clear: rd=%b active=%b idle=%b expected 0/0/1", vc1_rd_en, active_vc, idle); end
    do_reset();
  endtask

  task automatic test_random();
    bit to, a0, a1;
    for (int r = 0; r < 8; r++) begin
      a0 = bit'($urandom_range(0, 1)); a1 = bit'($urandom_range(0, 1));
      for (int n = $urandom_range(0, 5); n > 0; n--) load(1'b0, DW'($urandom));
      for (int n = $urandom_range(0, 5); n > 0; n--) load(1'b1, DW'($urandom));
      for (int ph = 0; ph < 2; ph++) begin
        clear_logs();
        if (ph == 0) begin d0_af = a0; d1_af = a1; end
        else begin d0_af = 1'b0; d1_af = 1'b0; end
        model_drain(d0_af, d1_af);
        drain(60, to);
        checks++; if (to || pop_vc.size() != exp_pop.size()) begin errors++;
          $display("FAIL rnd_count r%0d p%0d: got %0d pops timeout=%b expected %0d", r, ph, pop_vc.size(), to, exp_pop.size()); end
        for (int i = 0; i < exp_pop.size() && i < pop_vc.size(); i++) begin
          checks++; if (pop_vc[i] !== exp_pop[i]) begin errors++;
            $display("FAIL rnd_vc r%0d[%0d]: got VC%0d expected VC%0d", r, i, pop_vc[i], exp_pop[i]); end
        end
        for (int i = 0; i < exp_push.size(); i++) begin
          checks++; if (i >= push_log.size() || push_log[i] !== exp_push[i]) begin errors++;
            $display("FAIL rnd_push r%0d[%0d]: got %h expected %h", r, i, (i < push_log.size()) ? push_log[i] : 'x, exp_push[i]); end
        end
        checks++; if (cnt_d0 !== CW'(exp_cnt0) || cnt_d1 !== CW'(exp_cnt1)) begin errors++;
          $display("FAIL rnd_cnt r%0d: got %0d/%0d expected %0d/%0d", r, cnt_d0, cnt_d1, exp_cnt0, exp_cnt1); end
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [DW-1:0] w;
    init_pulse();
    for (int ph = 0; ph < 2; ph++) begin
      clear_logs();
      for (int i = 0; i < ((ph == 0) ? 255 : 1); i++) begin
        w = DW'($urandom); w[DB] = 1'b0; load(1'b0, w);
      end
      model_drain(1'b0, 1'b0);
      drain(255 * 3 + 40, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_timeout p%0d: drain not done expected done", ph); end
      checks++; if (cnt_d0 !== CW'(exp_cnt0) || cnt_d0 !== ((ph == 0) ? CW'(255) : CW'(0))) begin errors++;
        $display("FAIL wrap_cnt p%0d: got %0d expected %0d", ph, cnt_d0, (ph == 0) ? 255 : 0); end
    end
  endtask

  task automatic test_exclusion();
    checks++; if (viol != 0) begin errors++;
      $display("FAIL strobe_exclusive: got %0d cycles with >1 strobe expected 0", viol); end
  endtask

  initial begin
    reset = 1'b0; init = 1'b1; d0_af = 1'b0; d1_af = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_contention();
    test_mixed();
    test_init_mid();
    test_async_reset();
    test_random();
    test_wrap();
    test_exclusion();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached expected finish");
    $fatal(1);
  end

endmodule
